// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator.
//   - Pattern mode encodings.
//   - 640x480 timing constants.
//   - Pixel pipeline latency.
//   - Pipeline stage record.
//   - Pure colour function used by the output stage.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_GRID    = 2'd2,
        MODE_DIAG    = 2'd3
    } mode_e;

    // 640x480 @ 60 Hz timing, in pixels and lines.
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Cycles from timing inputs to registered colour/sync outputs.
    localparam int unsigned PIX_LAT = 2;

    localparam int unsigned CNT_W = 10;

    // One stage of the pixel pipeline: timing inputs carried unchanged.
    typedef struct packed {
        logic             visible;
        logic             hsync;
        logic             vsync;
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
    } stage_t;

    // Colour {r,g,b} for a given mode and position; ofs scrolls DIAG.
    function automatic logic [2:0] pattern_pixel(input mode_e            m,
                                                 input logic [CNT_W-1:0] h,
                                                 input logic [CNT_W-1:0] v,
                                                 input logic [5:0]       ofs);
        logic [10:0] sum;
        logic [2:0]  pix;
        // 11-bit sum wraps modulo 2^11 by construction.
        sum = {1'b0, h} + {1'b0, v} + {5'b0, ofs};
        pix = 3'b000;
        case (m)
            MODE_BARS:    pix = h[9:7];
            MODE_CHECKER: pix = {3{h[5] ^ v[5]}};
            MODE_GRID:    pix = {3{(h[5:0] == 6'd0) || (v[5:0] == 6'd0)}};
            MODE_DIAG:    pix = {3{sum[5]}};
            default:      pix = 3'b000;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Rising-edge detector for the frame (vSync) edge.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   din   in  level to watch
//   rise  out combinational: din high now, low on the previous cycle
// The previous-value register resets to 1 so a level already high when
// reset is released is not reported as an edge.
module vga_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= din;
        end
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: takes timing from an upstream generator and
// produces a 1-bit-per-channel colour pattern with sync/visible realigned.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   visible, hSync, vSync         timing inputs
//   hCount, vCount [9:0]          pixel / line position
//   mode_sel [1:0], mode_req      requested mode and capture strobe
//   r, g, b                       colour, PIX_LAT cycles after inputs
//   hSync_o, vSync_o, visible_o   timing, aligned with colour
//   mode [1:0]                    active mode (changes only on frame edge)
//   frame_cnt [7:0]               frame counter
// Build option: define VGA_PATTERN_ANIM_EN to enable the frame counter and
// DIAG scrolling; without it frame_cnt is tied to 0 and DIAG is static.
module vga_pattern_gen
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       visible,
    input  logic       hSync,
    input  logic       vSync,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic [1:0] mode_sel,
    input  logic       mode_req,
    output logic       r,
    output logic       g,
    output logic       b,
    output logic       hSync_o,
    output logic       vSync_o,
    output logic       visible_o,
    output logic [1:0] mode,
    output logic [7:0] frame_cnt
);

    // ------------------------------------------------------------------
    // Frame edge
    // ------------------------------------------------------------------
    logic frame_edge;

    vga_edge_det u_edge_det (
        .clk   (clk),
        .reset (reset),
        .din   (vSync),
        .rise  (frame_edge)
    );

    // ------------------------------------------------------------------
    // Mode control: requests are held pending and applied on a frame edge
    // ------------------------------------------------------------------
    mode_e mode_q, mode_d;
    mode_e pending_q, pending_d;
    logic  pending_valid_q, pending_valid_d;

    always_comb begin
        mode_d          = mode_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (frame_edge) begin
            // A request landing on the edge itself wins over older ones.
            if (mode_req) begin
                mode_d          = mode_e'(mode_sel);
                pending_d       = mode_e'(mode_sel);
                pending_valid_d = 1'b0;
            end else if (pending_valid_q) begin
                mode_d          = pending_q;
                pending_valid_d = 1'b0;
            end
        end else if (mode_req) begin
            pending_d       = mode_e'(mode_sel);
            pending_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q          <= MODE_BARS;
            pending_q       <= MODE_BARS;
            pending_valid_q <= 1'b0;
        end else begin
            mode_q          <= mode_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame counter and DIAG offset
    // ------------------------------------------------------------------
    logic [7:0] frame_cnt_q;
    logic [5:0] ofs;

`ifdef VGA_PATTERN_ANIM_EN
    logic [7:0] frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_edge) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign ofs = frame_cnt_q[5:0];
`else
    assign frame_cnt_q = 8'd0;
    assign ofs         = 6'd0;
`endif

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    stage_t     s1_q, s1_d;
    logic [2:0] rgb_q, rgb_d;
    logic       hsync_q, vsync_q, visible_q;

    always_comb begin
        s1_d.visible = visible;
        s1_d.hsync   = hSync;
        s1_d.vsync   = vSync;
        s1_d.hcount  = hCount;
        s1_d.vcount  = vCount;
    end

    // Colour uses the mode/frame state current when stage 2 is computed.
    always_comb begin
        rgb_d = 3'b000;
        if (s1_q.visible) begin
            rgb_d = pattern_pixel(mode_q, s1_q.hcount, s1_q.vcount, ofs);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            rgb_q     <= 3'b000;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            visible_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            rgb_q     <= rgb_d;
            hsync_q   <= s1_q.hsync;
            vsync_q   <= s1_q.vsync;
            visible_q <= s1_q.visible;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign r         = rgb_q[2];
    assign g         = rgb_q[1];
    assign b         = rgb_q[0];
    assign hSync_o   = hsync_q;
    assign vSync_o   = vsync_q;
    assign visible_o = visible_q;
    assign mode      = mode_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: table-driven pattern vectors
// plus hand-written latency, mode-switch, wrap and reset sequences.
module tb_vga_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       visible, hSync, vSync;
    logic [9:0] hCount, vCount;
    logic [1:0] mode_sel;
    logic       mode_req;
    logic       r, g, b, hSync_o, vSync_o, visible_o;
    logic [1:0] mode;
    logic [7:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    // Expected frame count: rising edges of vSync seen outside reset.
    logic [7:0] fc_exp  = 8'd0;
    logic       vs_prev = 1'b1;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .clk       (clk),
        .reset     (reset),
        .visible   (visible),
        .hSync     (hSync),
        .vSync     (vSync),
        .hCount    (hCount),
        .vCount    (vCount),
        .mode_sel  (mode_sel),
        .mode_req  (mode_req),
        .r         (r),
        .g         (g),
        .b         (b),
        .hSync_o   (hSync_o),
        .vSync_o   (vSync_o),
        .visible_o (visible_o),
        .mode      (mode),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        logic [1:0] mode;
        logic       vis;
        logic [9:0] h;
        logic [9:0] v;
        logic [2:0] rgb;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            vs_prev = 1'b1;
            fc_exp  = 8'd0;
        end else begin
            if (vSync && !vs_prev) fc_exp = fc_exp + 8'd1;
            vs_prev = vSync;
        end
        #1;
    endtask

    function automatic logic [7:0] exp_fc();
`ifdef VGA_PATTERN_ANIM_EN
        return fc_exp;
`else
        return 8'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Creates one frame edge with a request for m on the edge cycle.
    task automatic switch_mode(input logic [1:0] m);
        vSync    = 1'b0;
        mode_req = 1'b0;
        tick();
        vSync    = 1'b1;
        mode_req = 1'b1;
        mode_sel = m;
        tick();
        vSync    = 1'b0;
        mode_req = 1'b0;
        check("switch_mode", 32'(mode), 32'(m));
    endtask

    // One-cycle pulse on hSync (0), vSync (1) or visible (2).
    task automatic latency_test(input int which);
        logic out;
        case (which)
            0: hSync = 1'b1;
            1: vSync = 1'b1;
            default: visible = 1'b1;
        endcase
        tick();
        hSync   = 1'b0;
        vSync   = 1'b0;
        visible = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            case (which)
                0: out = hSync_o;
                1: out = vSync_o;
                default: out = visible_o;
            endcase
            check($sformatf("latency sig%0d cyc%0d", which, k), 32'(out), 32'(k == 2));
            tick();
        end
    endtask

    initial begin
        logic [1:0] cur_mode;
        logic [2:0] exp_rgb;

        reset    = 1'b1;
        visible  = 1'b0;
        hSync    = 1'b0;
        vSync    = 1'b0;
        hCount   = 10'd0;
        vCount   = 10'd0;
        mode_sel = 2'd0;
        mode_req = 1'b0;

        // Vectors ordered by mode; DIAG cases hold for offsets 0..3.
        vecs.push_back('{2'd0, 1'b1, 10'h180, 10'd0,   3'b011});
        vecs.push_back('{2'd0, 1'b0, 10'h180, 10'd0,   3'b000});
        vecs.push_back('{2'd0, 1'b1, 10'h3FF, 10'd5,   3'b111});
        vecs.push_back('{2'd0, 1'b1, 10'h280, 10'd9,   3'b101});
        vecs.push_back('{2'd0, 1'b1, 10'h07F, 10'd0,   3'b000});
        vecs.push_back('{2'd1, 1'b1, 10'd32,  10'd0,   3'b111});
        vecs.push_back('{2'd1, 1'b1, 10'd32,  10'd32,  3'b000});
        vecs.push_back('{2'd1, 1'b1, 10'd0,   10'd32,  3'b111});
        vecs.push_back('{2'd1, 1'b1, 10'd31,  10'd31,  3'b000});
        vecs.push_back('{2'd2, 1'b1, 10'd0,   10'd5,   3'b111});
        vecs.push_back('{2'd2, 1'b1, 10'd5,   10'd64,  3'b111});
        vecs.push_back('{2'd2, 1'b1, 10'd65,  10'd65,  3'b000});
        vecs.push_back('{2'd2, 1'b1, 10'd128, 10'd3,   3'b111});
        vecs.push_back('{2'd2, 1'b1, 10'd63,  10'd1,   3'b000});
        vecs.push_back('{2'd2, 1'b0, 10'd0,   10'd0,   3'b000});
        vecs.push_back('{2'd3, 1'b1, 10'd40,  10'd0,   3'b111});
        vecs.push_back('{2'd3, 1'b1, 10'd100, 10'd100, 3'b000});
        vecs.push_back('{2'd3, 1'b1, 10'd16,  10'd16,  3'b111});
        vecs.push_back('{2'd3, 1'b1, 10'd500, 10'd300, 3'b111});
        vecs.push_back('{2'd3, 1'b1, 10'd1000, 10'd1000, 3'b000});
        vecs.push_back('{2'd3, 1'b1, 10'd0,   10'd0,   3'b000});
        vecs.push_back('{2'd3, 1'b0, 10'd40,  10'd0,   3'b000});

        // Reset state
        tick();
        tick();
        check("reset rgb",       32'({r, g, b}), 32'd0);
        check("reset hSync_o",   32'(hSync_o), 32'd0);
        check("reset vSync_o",   32'(vSync_o), 32'd0);
        check("reset visible_o", 32'(visible_o), 32'd0);
        check("reset mode",      32'(mode), 32'd0);
        check("reset frame_cnt", 32'(frame_cnt), 32'd0);
        reset = 1'b0;
        tick();

        // Latency
        latency_test(0);
        latency_test(1);
        latency_test(2);
        check("latency frame_cnt", 32'(frame_cnt), 32'(exp_fc()));

        // Deferred switch from mode 0 to 2
        do_reset();
        tick();
        vCount   = 10'd100;
        mode_sel = 2'd2;
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        mode_sel = 2'd1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("defer hold", 32'(mode), 32'd0);
        end
        vSync = 1'b1;
        tick();
        check("defer applied", 32'(mode), 32'd2);
        vSync = 1'b0;
        tick();

        // Two requests in one frame: the later one wins
        mode_sel = 2'd1;
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        tick();
        mode_sel = 2'd3;
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        check("simul before edge", 32'(mode), 32'd2);
        vSync = 1'b1;
        tick();
        check("simul last wins", 32'(mode), 32'd3);
        vSync = 1'b0;
        tick();
        // Request on the edge cycle is applied at that edge
        vSync    = 1'b1;
        mode_sel = 2'd0;
        mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        vSync    = 1'b0;
        check("simul on edge", 32'(mode), 32'd0);
        tick();
        // Nothing left pending: next edge keeps the mode
        vSync = 1'b1;
        tick();
        vSync = 1'b0;
        check("simul no pending", 32'(mode), 32'd0);
        check("simul frame_cnt", 32'(frame_cnt), 32'(exp_fc()));
        tick();

        // Pattern table
        do_reset();
        cur_mode = 2'd0;
        foreach (vecs[i]) begin
            if (vecs[i].mode != cur_mode) begin
                switch_mode(vecs[i].mode);
                cur_mode = vecs[i].mode;
            end
            visible = vecs[i].vis;
            hCount  = vecs[i].h;
            vCount  = vecs[i].v;
            tick();
            tick();
            check($sformatf("vec%0d rgb", i), 32'({r, g, b}), 32'(vecs[i].rgb));
            check($sformatf("vec%0d visible_o", i), 32'(visible_o), 32'(vecs[i].vis));
        end
        visible = 1'b0;

        // Frame counter wrap and DIAG animation at origin
        do_reset();
        switch_mode(2'd3);
        visible = 1'b1;
        hCount  = 10'd0;
        vCount  = 10'd0;
        for (int k = 0; k < 255; k++) begin
            vSync = 1'b1;
            tick();
            vSync = 1'b0;
            tick();
            check("wrap frame_cnt", 32'(frame_cnt), 32'(exp_fc()));
            if (fc_exp == 8'd31 || fc_exp == 8'd32 || fc_exp == 8'd33) begin
`ifdef VGA_PATTERN_ANIM_EN
                exp_rgb = {3{fc_exp[5]}};
`else
                exp_rgb = 3'b000;
`endif
                check($sformatf("diag anim fc%0d", fc_exp), 32'({r, g, b}), 32'(exp_rgb));
            end
        end
        check("wrap to zero", 32'(frame_cnt), 32'd0);

        // Reset mid-frame with vSync held high through release
        hCount  = 10'h180;
        vCount  = 10'd200;
        visible = 1'b1;
        tick();
        tick();
        check("midframe visible_o", 32'(visible_o), 32'd1);
        reset = 1'b1;
        vSync = 1'b1;
        hSync = 1'b1;
        tick();
        check("midrst rgb",       32'({r, g, b}), 32'd0);
        check("midrst visible_o", 32'(visible_o), 32'd0);
        check("midrst hSync_o",   32'(hSync_o), 32'd0);
        check("midrst vSync_o",   32'(vSync_o), 32'd0);
        check("midrst mode",      32'(mode), 32'd0);
        check("midrst frame_cnt", 32'(frame_cnt), 32'd0);
        reset = 1'b0;
        hSync = 1'b0;
        tick();
        check("release cyc1 visible_o", 32'(visible_o), 32'd0);
        check("release cyc1 frame_cnt", 32'(frame_cnt), 32'd0);
        tick();
        check("release cyc2 visible_o", 32'(visible_o), 32'd1);
        check("release cyc2 rgb",       32'({r, g, b}), 32'd3);
        check("release cyc2 vSync_o",   32'(vSync_o), 32'd1);
        check("release no edge",        32'(frame_cnt), 32'd0);
        vSync = 1'b0;
        tick();
        vSync = 1'b1;
        tick();
        check("release later edge", 32'(frame_cnt), 32'(exp_fc()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
